// File: rtl/board_io_pkg.sv
// ---------------------------------------------------------------------------
// board_io_pkg : shared types for the board-level PWM bank
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package board_io_pkg;

  // Config fields are carried at a fixed maximum width so the struct can
  // live in the package; the bank zero-extends its narrower inputs.
  localparam int CFG_DUTY_W = 16;
  localparam int CFG_STEP_W = 8;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STATIC = 2'd1,
    MODE_FADE   = 2'd2,
    MODE_ON     = 2'd3
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } fade_dir_e;

  typedef struct packed {
    pwm_mode_e              mode;
    logic [CFG_DUTY_W-1:0]  duty;
    logic [CFG_STEP_W-1:0]  step;
  } ch_cfg_t;

endpackage

`default_nettype wire

// File: rtl/board_pwm_channel.sv
// ---------------------------------------------------------------------------
// board_pwm_channel : one PWM channel with active config and fade state
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module board_pwm_channel
  import board_io_pkg::*;
#(
  parameter int PWM_W      = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] cnt,
  input  logic             boundary,
  input  logic             commit,
  input  ch_cfg_t          cfg,
  output logic             pwm
);

  localparam int AW = CFG_DUTY_W + 1;
  localparam logic [CFG_DUTY_W-1:0] FULL = CFG_DUTY_W'((1 << PWM_W) - 1);

  pwm_mode_e              mode_q;
  logic [CFG_DUTY_W-1:0]  duty_q;
  logic [CFG_STEP_W-1:0]  step_q;
  logic [CFG_DUTY_W-1:0]  fade_q;
  fade_dir_e              dir_q;

  logic [CFG_DUTY_W-1:0]  lvl;
  logic [CFG_DUTY_W-1:0]  fade_nxt;
  fade_dir_e              dir_nxt;
  logic [AW-1:0]          sum;

  always_comb begin
    case (mode_q)
      MODE_STATIC: lvl = duty_q;
      MODE_FADE:   lvl = fade_q;
      MODE_ON:     lvl = FULL;
      default:     lvl = '0;
    endcase
  end

  // Triangle fade saturating at the peak (duty) on the way up and at 0 down.
  always_comb begin
    sum      = AW'(fade_q) + AW'(step_q);
    fade_nxt = fade_q;
    dir_nxt  = dir_q;
    if (dir_q == DIR_UP) begin
      if (sum >= AW'(duty_q)) begin
        fade_nxt = duty_q;
        dir_nxt  = DIR_DOWN;
      end else begin
        fade_nxt = sum[CFG_DUTY_W-1:0];
      end
    end else begin
      if (AW'(fade_q) <= AW'(step_q)) begin
        fade_nxt = '0;
        dir_nxt  = DIR_UP;
      end else begin
        fade_nxt = fade_q - CFG_DUTY_W'(step_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_OFF;
      duty_q <= '0;
      step_q <= '0;
      fade_q <= '0;
      dir_q  <= DIR_UP;
      pwm    <= ACTIVE_LOW;
    end else begin
      pwm <= (CFG_DUTY_W'(cnt) < lvl) ^ ACTIVE_LOW;
      // A commit overrides any fade update due on the same boundary.
      if (commit) begin
        mode_q <= cfg.mode;
        duty_q <= cfg.duty;
        step_q <= cfg.step;
        fade_q <= '0;
        dir_q  <= DIR_UP;
      end else if (boundary && (mode_q == MODE_FADE)) begin
        fade_q <= fade_nxt;
        dir_q  <= dir_nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/board_pwm_bank.sv
// ---------------------------------------------------------------------------
// board_pwm_bank : N-channel PWM driver with period-aligned config commits
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module board_pwm_bank
  import board_io_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int PWM_W      = 8,
  parameter int PRESCALE   = 47,
  parameter int STEP_W     = 4,
  parameter int ACTIVE_LOW = 1,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              pll_clk,
  input  logic              pll_rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [PWM_W-1:0]  cfg_duty,
  input  logic [STEP_W-1:0] cfg_step,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start
);

  localparam int PSC_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE);
  localparam logic [PWM_W-1:0] CNT_MAX = PWM_W'((1 << PWM_W) - 2);

  logic [PSC_W-1:0] psc_q;
  logic [PWM_W-1:0] cnt_q;
  logic             tick;
  logic             boundary;
  logic             accept;

  logic             pend_q;
  logic [CH_W-1:0]  pend_ch_q;
  ch_cfg_t          pend_cfg_q;

  assign tick      = (psc_q == PSC_MAX);
  assign boundary  = tick && (cnt_q == CNT_MAX);
  assign cfg_ready = !pend_q;
  assign accept    = cfg_valid && !pend_q;

  always_ff @(posedge pll_clk or negedge pll_rst_n) begin
    if (!pll_rst_n) begin
      psc_q        <= '0;
      cnt_q        <= '0;
      period_start <= 1'b0;
      pend_q       <= 1'b0;
      pend_ch_q    <= '0;
      pend_cfg_q   <= '0;
    end else begin
      period_start <= boundary;
      if (tick) begin
        psc_q <= '0;
        cnt_q <= boundary ? '0 : cnt_q + 1'b1;
      end else begin
        psc_q <= psc_q + 1'b1;
      end
      // The slot is only ever full or being filled, never both at once,
      // so a write landing on a boundary simply waits one more period.
      if (boundary && pend_q) begin
        pend_q <= 1'b0;
      end else if (accept) begin
        pend_q     <= 1'b1;
        pend_ch_q  <= cfg_ch;
        pend_cfg_q <= '{mode: pwm_mode_e'(cfg_mode),
                        duty: CFG_DUTY_W'(cfg_duty),
                        step: CFG_STEP_W'(cfg_step)};
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    board_pwm_channel #(
      .PWM_W      (PWM_W),
      .ACTIVE_LOW (ACTIVE_LOW != 0)
    ) u_ch (
      .clk      (pll_clk),
      .rst_n    (pll_rst_n),
      .cnt      (cnt_q),
      .boundary (boundary),
      .commit   (boundary && pend_q && (pend_ch_q == CH_W'(i))),
      .cfg      (pend_cfg_q),
      .pwm      (pwm_out[i])
    );
  end

endmodule

`default_nettype wire
